// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// Forwarding build option: FORWARDING_EN (see pipeline_ctrl.sv).
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MEMWAIT = 2'd1,
      ST_HALT    = 2'd2
   } state_e;

   localparam logic [1:0]  FWD_DE = 2'b00;
   localparam logic [1:0]  FWD_EM = 2'b10;
   localparam logic [1:0]  FWD_MW = 2'b01;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // x0 is hardwired to zero, so a write to it never creates a dependency
   function automatic logic rd_hit(input logic [4:0] rs, input logic [4:0] rd,
                                   input logic we);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_em, input logic we_em,
                                          input logic [4:0] rd_mw, input logic we_mw);
      if (rd_hit(rs, rd_em, we_em))
         return FWD_EM;
      else if (rd_hit(rs, rd_mw, we_mw))
         return FWD_MW;
      else
         return FWD_DE;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW / load-use detection and operand-forwarding select.
// FORWARDING_EN selects load-use-only stalling plus bypass; otherwise stall on any RAW.
module pipeline_ctrl_hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [4:0] rs1_id_i,
   input  logic [4:0] rs2_id_i,
   input  logic [4:0] rs1_de_i,
   input  logic [4:0] rs2_de_i,
   input  logic [4:0] rd_de_i,
   input  logic       regwrite_de_i,
   input  logic       memread_de_i,
   input  logic [4:0] rd_em_i,
   input  logic       regwrite_em_i,
   input  logic [4:0] rd_mw_i,
   input  logic       regwrite_mw_i,
   output logic       stall_req_o,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   logic de_hit;
   logic em_hit;
   logic mw_hit;

   assign de_hit = rd_hit(rs1_id_i, rd_de_i, regwrite_de_i) | rd_hit(rs2_id_i, rd_de_i, regwrite_de_i);
   assign em_hit = rd_hit(rs1_id_i, rd_em_i, regwrite_em_i) | rd_hit(rs2_id_i, rd_em_i, regwrite_em_i);
   assign mw_hit = rd_hit(rs1_id_i, rd_mw_i, regwrite_mw_i) | rd_hit(rs2_id_i, rd_mw_i, regwrite_mw_i);

`ifdef FORWARDING_EN
   logic unused_fwd_hits;
   assign unused_fwd_hits = em_hit ^ mw_hit;

   // Only a load result is too late to bypass into the dependent instruction
   assign stall_req_o = memread_de_i & de_hit;
   assign fwd_a_o     = fwd_sel(rs1_de_i, rd_em_i, regwrite_em_i, rd_mw_i, regwrite_mw_i);
   assign fwd_b_o     = fwd_sel(rs2_de_i, rd_em_i, regwrite_em_i, rd_mw_i, regwrite_mw_i);
`else
   logic unused_nofwd_in;
   assign unused_nofwd_in = ^{rs1_de_i, rs2_de_i, memread_de_i};

   // Without bypass paths, the consumer waits in ID until every producer has written back
   assign stall_req_o = de_hit | em_hit | mw_hit;
   assign fwd_a_o     = FWD_DE;
   assign fwd_b_o     = FWD_DE;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush/forward controller with data-memory timeout trap.
// Build option: define FORWARDING_EN to enable EX operand bypassing.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TO = 255
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] RS1_ID,
   input  logic [4:0] RS2_ID,
   input  logic [4:0] RS1_DE,
   input  logic [4:0] RS2_DE,
   input  logic [4:0] RD_DE,
   input  logic       RegWrite_DE,
   input  logic       MemRead_DE,
   input  logic [4:0] RD_EM,
   input  logic       RegWrite_EM,
   input  logic [4:0] RD_MW,
   input  logic       RegWrite_MW,
   input  logic       BR_TAKEN_E,
   input  logic       DMEM_REQ_M,
   input  logic       DMEM_ACK_M,
   output logic       STALL_FD,
   output logic       STALL_DE,
   output logic       STALL_EM,
   output logic       FLUSH_FD,
   output logic       FLUSH_DE,
   output logic       BUBBLE_MW,
   output logic [1:0] FWD_A,
   output logic [1:0] FWD_B,
   output logic       TRAP
);

   localparam logic [7:0] MEM_TO_C = 8'(MEM_TO);

   state_e     state_q, state_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       mem_wait;
   logic       hold_all;
   logic       hz_stall;

   assign mem_wait = DMEM_REQ_M & ~DMEM_ACK_M;

   pipeline_ctrl_hazard_detect hazard_detect (
      .rs1_id_i      (RS1_ID),
      .rs2_id_i      (RS2_ID),
      .rs1_de_i      (RS1_DE),
      .rs2_de_i      (RS2_DE),
      .rd_de_i       (RD_DE),
      .regwrite_de_i (RegWrite_DE),
      .memread_de_i  (MemRead_DE),
      .rd_em_i       (RD_EM),
      .regwrite_em_i (RegWrite_EM),
      .rd_mw_i       (RD_MW),
      .regwrite_mw_i (RegWrite_MW),
      .stall_req_o   (hz_stall),
      .fwd_a_o       (FWD_A),
      .fwd_b_o       (FWD_B)
   );

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_RUN: begin
            if (mem_wait) begin
               state_d = ST_MEMWAIT;
               wcnt_d  = 8'd0;
            end
         end
         ST_MEMWAIT: begin
            if (DMEM_ACK_M) begin
               state_d = ST_RUN;
            end else begin
               if (wcnt_q != MEM_TO_C)
                  wcnt_d = wcnt_q + 8'd1;
               if ((wcnt_q + 8'd1) >= MEM_TO_C)
                  state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_RUN;
         wcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // The ACK cycle releases the pipeline, so a held branch in EX is resolved right then
   assign hold_all = (state_q == ST_HALT)
                   | ((state_q == ST_MEMWAIT) & ~DMEM_ACK_M)
                   | ((state_q == ST_RUN) & mem_wait);

   always_comb begin
      STALL_FD  = 1'b0;
      STALL_DE  = 1'b0;
      STALL_EM  = 1'b0;
      FLUSH_FD  = 1'b0;
      FLUSH_DE  = 1'b0;
      BUBBLE_MW = 1'b0;
      if (hold_all) begin
         STALL_FD  = 1'b1;
         STALL_DE  = 1'b1;
         STALL_EM  = 1'b1;
         BUBBLE_MW = 1'b1;
      end else if (BR_TAKEN_E) begin
         FLUSH_FD = 1'b1;
         FLUSH_DE = 1'b1;
      end else if (hz_stall) begin
         STALL_FD = 1'b1;
         FLUSH_DE = 1'b1;
      end
   end

   assign TRAP = (state_q == ST_HALT);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl (MEM_TO=4); expectations follow FORWARDING_EN.
module tb_pipeline_ctrl;

`ifdef FORWARDING_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   // ctrl = {STALL_FD, STALL_DE, STALL_EM, FLUSH_FD, FLUSH_DE, BUBBLE_MW, TRAP}
   localparam logic [6:0] C_IDLE   = 7'b000_0000;
   localparam logic [6:0] C_LDUSE  = 7'b100_0100;
   localparam logic [6:0] C_BRANCH = 7'b000_1100;
   localparam logic [6:0] C_MWAIT  = 7'b111_0010;
   localparam logic [6:0] C_HALT   = 7'b111_0011;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] RS1_ID, RS2_ID, RS1_DE, RS2_DE, RD_DE, RD_EM, RD_MW;
   logic       RegWrite_DE, MemRead_DE, RegWrite_EM, RegWrite_MW;
   logic       BR_TAKEN_E, DMEM_REQ_M, DMEM_ACK_M;
   logic       STALL_FD, STALL_DE, STALL_EM, FLUSH_FD, FLUSH_DE, BUBBLE_MW, TRAP;
   logic [1:0] FWD_A, FWD_B;
   logic [6:0] ctrl;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.MEM_TO(4)) dut (
      .CLK(CLK), .RST(RST),
      .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RS1_DE(RS1_DE), .RS2_DE(RS2_DE),
      .RD_DE(RD_DE), .RegWrite_DE(RegWrite_DE), .MemRead_DE(MemRead_DE),
      .RD_EM(RD_EM), .RegWrite_EM(RegWrite_EM),
      .RD_MW(RD_MW), .RegWrite_MW(RegWrite_MW),
      .BR_TAKEN_E(BR_TAKEN_E), .DMEM_REQ_M(DMEM_REQ_M), .DMEM_ACK_M(DMEM_ACK_M),
      .STALL_FD(STALL_FD), .STALL_DE(STALL_DE), .STALL_EM(STALL_EM),
      .FLUSH_FD(FLUSH_FD), .FLUSH_DE(FLUSH_DE), .BUBBLE_MW(BUBBLE_MW),
      .FWD_A(FWD_A), .FWD_B(FWD_B), .TRAP(TRAP)
   );

   assign ctrl = {STALL_FD, STALL_DE, STALL_EM, FLUSH_FD, FLUSH_DE, BUBBLE_MW, TRAP};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clr();
      RS1_ID = 5'd0; RS2_ID = 5'd0; RS1_DE = 5'd0; RS2_DE = 5'd0;
      RD_DE = 5'd0; RD_EM = 5'd0; RD_MW = 5'd0;
      RegWrite_DE = 1'b0; MemRead_DE = 1'b0; RegWrite_EM = 1'b0; RegWrite_MW = 1'b0;
      BR_TAKEN_E = 1'b0; DMEM_REQ_M = 1'b0; DMEM_ACK_M = 1'b0;
   endtask

   initial begin
      clr();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
      settle();
      chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
      chk("reset_fwda", 32'(FWD_A), 32'd0);
      chk("reset_fwdb", 32'(FWD_B), 32'd0);

      // lw x5 in DE, add x6,x5,x1 in FD
      tick(); clr();
      RD_DE = 5'd5; RegWrite_DE = 1'b1; MemRead_DE = 1'b1; RS1_ID = 5'd5; RS2_ID = 5'd1;
      settle();
      chk("lduse_stall", 32'(ctrl), 32'(C_LDUSE));
      // bubble in DE, lw in EM, add still in FD
      tick(); clr();
      RD_EM = 5'd5; RegWrite_EM = 1'b1; RS1_ID = 5'd5; RS2_ID = 5'd1;
      settle();
      chk("lduse_after", 32'(ctrl), FWD_ON ? 32'(C_IDLE) : 32'(C_LDUSE));
      // lw in MW, add in DE
      tick(); clr();
      RD_MW = 5'd5; RegWrite_MW = 1'b1; RS1_DE = 5'd5; RS2_DE = 5'd1;
      settle();
      chk("lduse_fwda", 32'(FWD_A), FWD_ON ? 32'd1 : 32'd0);
      chk("lduse_fwdb", 32'(FWD_B), 32'd0);
      chk("lduse_ex_ctrl", 32'(ctrl), 32'(C_IDLE));

      // EM and MW both write x7: EM wins
      tick(); clr();
      RD_EM = 5'd7; RegWrite_EM = 1'b1; RD_MW = 5'd7; RegWrite_MW = 1'b1;
      RS1_DE = 5'd7; RS2_DE = 5'd7;
      settle();
      chk("fwd_em_a", 32'(FWD_A), FWD_ON ? 32'd2 : 32'd0);
      chk("fwd_em_b", 32'(FWD_B), FWD_ON ? 32'd2 : 32'd0);
      RD_EM = 5'd0;
      settle();
      chk("fwd_emx0_a", 32'(FWD_A), FWD_ON ? 32'd1 : 32'd0);
      RD_EM = 5'd7; RegWrite_EM = 1'b0;
      settle();
      chk("fwd_em_nowr", 32'(FWD_A), FWD_ON ? 32'd1 : 32'd0);
      // operand x0 never forwards
      RD_EM = 5'd0; RegWrite_EM = 1'b1; RD_MW = 5'd0; RS1_DE = 5'd0; RS2_DE = 5'd4;
      settle();
      chk("fwd_x0_a", 32'(FWD_A), 32'd0);
      chk("fwd_x0_b", 32'(FWD_B), 32'd0);

      // ALU producer in DE (no load): only the non-bypass build stalls
      tick(); clr();
      RD_DE = 5'd9; RegWrite_DE = 1'b1; RS2_ID = 5'd9;
      settle();
      chk("raw_alu_de", 32'(ctrl), FWD_ON ? 32'(C_IDLE) : 32'(C_LDUSE));
      // load to x0 never stalls
      RD_DE = 5'd0; MemRead_DE = 1'b1; RS2_ID = 5'd0;
      settle();
      chk("lduse_x0", 32'(ctrl), 32'(C_IDLE));
      // load-use via rs2
      RD_DE = 5'd12; RS1_ID = 5'd3; RS2_ID = 5'd12;
      settle();
      chk("lduse_rs2", 32'(ctrl), 32'(C_LDUSE));
      // branch beats load-use
      BR_TAKEN_E = 1'b1;
      settle();
      chk("br_over_lduse", 32'(ctrl), 32'(C_BRANCH));

      // MW writes x3, FD reads x3 via rs2
      tick(); clr();
      RD_MW = 5'd3; RegWrite_MW = 1'b1; RS2_ID = 5'd3;
      settle();
      chk("raw_mw_ctrl", 32'(ctrl), FWD_ON ? 32'(C_IDLE) : 32'(C_LDUSE));
      chk("raw_mw_fwdb", 32'(FWD_B), 32'd0);

      // memory wait of 3 cycles, branch arriving mid-wait is deferred
      tick(); clr();
      DMEM_REQ_M = 1'b1;
      settle();
      chk("mw_entry", 32'(ctrl), 32'(C_MWAIT));
      tick();
      settle();
      chk("mw_cyc1", 32'(ctrl), 32'(C_MWAIT));
      tick();
      BR_TAKEN_E = 1'b1;
      settle();
      chk("mw_cyc2_br", 32'(ctrl), 32'(C_MWAIT));
      tick();
      DMEM_ACK_M = 1'b1;
      settle();
      chk("mw_ack_br", 32'(ctrl), 32'(C_BRANCH));
      tick(); clr();
      settle();
      chk("mw_back_run", 32'(ctrl), 32'(C_IDLE));

      // no ACK: four MEMWAIT cycles then HALT
      tick();
      DMEM_REQ_M = 1'b1;
      settle();
      chk("to_entry", 32'(ctrl), 32'(C_MWAIT));
      for (int i = 1; i <= 4; i++) begin
         tick();
         settle();
         chk($sformatf("to_wait%0d", i), 32'(ctrl), 32'(C_MWAIT));
      end
      tick();
      settle();
      chk("to_halt", 32'(ctrl), 32'(C_HALT));
      tick(); clr();
      DMEM_ACK_M = 1'b1; BR_TAKEN_E = 1'b1;
      settle();
      chk("halt_sticky", 32'(ctrl), 32'(C_HALT));
      tick();
      RST = 1'b1;
      tick();
      RST = 1'b0; clr();
      settle();
      chk("halt_rst", 32'(ctrl), 32'(C_IDLE));

      // reset in the middle of a memory wait
      tick();
      DMEM_REQ_M = 1'b1;
      tick();
      tick();
      settle();
      chk("mid_wait", 32'(ctrl), 32'(C_MWAIT));
      RST = 1'b1;
      tick();
      RST = 1'b0; clr();
      settle();
      chk("mid_wait_rst", 32'(ctrl), 32'(C_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
